down_counter_parallel_load: RTL

//  Loadable binary down-counter. It is the count-down counterpart of the lab's
//  up-counter with parallel load, built for the counters experiment set.
//  - Borrow output cascades into the next (more significant) stage's decrement.
//  - Three terminal-count modes: wrap, auto-reload and one-shot. Together they

---
 rtl/counters_pkg.sv | 18 +
 rtl/down_counter_parallel_load_if.sv | 24 ++
 rtl/down_count_stage.sv | 34 +++
 rtl/down_counter_parallel_load.sv | 85 ++++++++
 4 files changed

// File: rtl/counters_pkg.sv
// Shared encodings for the counters lab: terminal-count modes and FSM states.
package counters_pkg;

  // Terminal-count behaviour selected by the mode input; 2'b11 behaves as wrap.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_e;

  // Counter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/down_counter_parallel_load_if.sv
// Control/data bundle for one down-counter stage. The master drives load,
// decrement, mode and I; the slave (the counter) returns the count and flags.
interface down_counter_parallel_load_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic             decrement;
  logic [1:0]       mode;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] A;
  logic             output_borrow;
  logic             zero;
  logic             expired;

  modport master (
    output load, decrement, mode, I,
    input  A, output_borrow, zero, expired
  );

  modport slave (
    input  load, decrement, mode, I,
    output A, output_borrow, zero, expired
  );
endinterface

// File: rtl/down_count_stage.sv
// One bit of the down-counter: loads a bit, or toggles when every lower bit is
// zero (borrow ripples in), and passes the borrow on while this bit is zero.
module down_count_stage
  import counters_pkg::*;
(
  input  logic clock,
  input  logic clear_n,
  input  logic i_borrow,
  input  logic i_load,
  input  logic i_load_bit,
  input  logic i_dec,
  output logic o_q,
  output logic o_borrow
);

  logic r_q;

  // Bit register: load has priority over decrement; otherwise hold.
  always_ff @(posedge clock or negedge clear_n) begin
    // NOTE: sequential state is written with <= so every stage samples the
    // pre-edge values of its neighbours, regardless of block evaluation order.
    if (!clear_n) begin
      r_q <= 1'b0;
    end else if (i_load) begin
      r_q <= i_load_bit;
    end else if (i_dec && i_borrow) begin
      r_q <= ~r_q;
    end
  end

  assign o_q      = r_q;
  assign o_borrow = i_borrow & ~r_q;

endmodule

// File: rtl/down_counter_parallel_load.sv
// Loadable binary down-counter with wrap, auto-reload and one-shot terminal
// behaviour. A bit-slice chain holds the count; this level owns the FSM, the
// reload value and the registered terminal-count flag.
module down_counter_parallel_load
  import counters_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                          clock,
  input  logic                          clear_n,
  down_counter_parallel_load_if.slave   bus
);

  logic [WIDTH:0]   w_borrow;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_load_val;
  logic             w_zero;
  logic             w_counting;
  logic             w_dec_req;
  logic             w_terminal;
  logic             w_cell_load;
  logic             w_cell_dec;

  state_e           r_state;
  logic [WIDTH-1:0] r_reload;
  logic             r_expired;

  // The ripple borrow out of the top bit is exactly "count is zero".
  assign w_borrow[0] = 1'b1;
  assign w_zero      = w_borrow[WIDTH];
  assign w_counting  = (r_state == ST_RUN);
  assign w_dec_req   = w_counting & bus.decrement & ~bus.load;
  assign w_terminal  = w_dec_req & w_zero;

  // Reload at the terminal edge reuses the cells' parallel-load path; wrap is
  // the natural toggle of an all-zero count; one-shot simply stops decrementing.
  assign w_cell_load = bus.load | (w_terminal & (bus.mode == MODE_RELOAD));
  assign w_load_val  = bus.load ? bus.I : r_reload;
  assign w_cell_dec  = w_dec_req & ~(w_zero & (bus.mode == MODE_ONESHOT));

  for (genvar g = 0; g < WIDTH; g++) begin : g_stage
    down_count_stage u_stage (
      .clock      (clock),
      .clear_n    (clear_n),
      .i_borrow   (w_borrow[g]),
      .i_load     (w_cell_load),
      .i_load_bit (w_load_val[g]),
      .i_dec      (w_cell_dec),
      .o_q        (w_q[g]),
      .o_borrow   (w_borrow[g+1])
    );
  end

  // Sequencing FSM with reload register and terminal-count flag.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state   <= ST_IDLE;
      r_reload  <= '0;
      r_expired <= 1'b0;
    end else if (bus.load) begin
      r_state   <= ST_RUN;
      r_reload  <= bus.I;
      r_expired <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.decrement && w_zero) begin
            r_expired <= 1'b1;
            if (bus.mode == MODE_ONESHOT) r_state <= ST_DONE;
          end else begin
            r_expired <= 1'b0;
          end
        end
        // DONE keeps its sticky flag; IDLE ignores decrement.
        default: ;
      endcase
    end
  end

  assign bus.A             = w_q;
  assign bus.zero          = w_zero;
  assign bus.output_borrow = bus.decrement & w_counting & w_zero;
  assign bus.expired       = r_expired;

endmodule
